// File: rtl/sys_mem_arb_nx.sv
// sys_mem_arb_nx: N-agent arbiter between Cortex engines and the system memory controller
//
// Fixed-priority or round-robin arbitration, selectable at runtime, with burst grant hold.
// Commands reach the controller combinationally in the cycle they are accepted.
// A read-tag FIFO routes in-order read data back to the agent that issued the read.
// Control and status registers sit on the local bus (LB).
//
// Optional build macro SYS_MEM_ARB_STATS_EN adds per-agent saturating grant counters at LB 0x10+i.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lb_wr_en/lb_rd_en/lb_addr/lb_wr_data        LB strobes, address and write data
//   lb_wr_valid/lb_rd_valid/lb_rd_data          LB acknowledge and read data, one cycle after the strobe
//   agent_wren/agent_rden/agent_addr/agent_wdata  per-agent requests, packed by agent index
//   agent_wait                    request not accepted this cycle
//   agent_rd_valid/agent_rdata    one-hot read return and broadcast read data
//   cntrlr_rdy                    controller can accept a command
//   cntrlr_wren/cntrlr_rden/cntrlr_addr/cntrlr_wdata  command to the controller
//   cntrlr_rd_valid/cntrlr_rdata  in-order read data from the controller
module sys_mem_arb_nx #(
    parameter int LB_DATA_W = 32,
    parameter int LB_ADDR_W = 12,
    parameter int MEM_DATA_W = 32,
    parameter int MEM_ADDR_W = 27,
    parameter int NUM_AGENTS = 4,
    parameter int BURST_LEN = 4,
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             lb_wr_en,
    input  logic                             lb_rd_en,
    input  logic [LB_ADDR_W-1:0]             lb_addr,
    input  logic [LB_DATA_W-1:0]             lb_wr_data,
    output logic                             lb_wr_valid,
    output logic                             lb_rd_valid,
    output logic [LB_DATA_W-1:0]             lb_rd_data,
    input  logic [NUM_AGENTS-1:0]            agent_wren,
    input  logic [NUM_AGENTS-1:0]            agent_rden,
    input  logic [NUM_AGENTS*MEM_ADDR_W-1:0] agent_addr,
    input  logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_wdata,
    output logic [NUM_AGENTS-1:0]            agent_wait,
    output logic [NUM_AGENTS-1:0]            agent_rd_valid,
    output logic [MEM_DATA_W-1:0]            agent_rdata,
    input  logic                             cntrlr_rdy,
    output logic                             cntrlr_wren,
    output logic                             cntrlr_rden,
    output logic [MEM_ADDR_W-1:0]            cntrlr_addr,
    output logic [MEM_DATA_W-1:0]            cntrlr_wdata,
    input  logic                             cntrlr_rd_valid,
    input  logic [MEM_DATA_W-1:0]            cntrlr_rdata
);
    localparam int AW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam int TW = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BL = BW'(BURST_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_AGENTS - 1);

    logic                  en, mode;
    logic [NUM_AGENTS-1:0] req, grant;
    logic [AW-1:0]         last, rr_ptr, ptr_eff, rr_win, fp_win, win;
    logic [BW-1:0]         burst_cnt, burst_nxt;
    logic                  hold, drop, win_wr, win_rd, issue;
    logic [AW-1:0]         tag_mem [2**TW];
    logic [TW-1:0]         wp, rp;
    logic [TW:0]           tag_cnt;
    logic                  full, push, pop, underflow, rd_underflow;
    logic                  ctl_wr, st_wr, stat_hit;
    logic [LB_DATA_W-1:0]  stat_rd, rd_mux;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
        return (a == LAST_IDX) ? '0 : a + 1'b1;
    endfunction

    assign req = agent_wren | agent_rden;

    // A burst in progress keeps the grant while its owner still requests; once the owner
    // drops out early the round-robin search restarts just after it.
    assign hold = burst_cnt != '0 && burst_cnt < BL && req[last];
    assign drop = burst_cnt != '0 && burst_cnt < BL && !req[last];
    assign ptr_eff = drop ? inc(last) : rr_ptr;

    // Both searches run from the far end so the last hit is the highest-priority one.
    always_comb begin
        int j;
        j = 0;
        fp_win = '0;
        rr_win = ptr_eff;
        for (int k = NUM_AGENTS - 1; k >= 0; k--) begin
            if (req[k]) fp_win = AW'(k);
        end
        for (int k = NUM_AGENTS - 1; k >= 0; k--) begin
            j = int'(ptr_eff) + k;
            j = (j >= NUM_AGENTS) ? j - NUM_AGENTS : j;
            if (req[j]) rr_win = AW'(j);
        end
    end

    assign win = hold ? last : (mode ? rr_win : fp_win);
    assign win_wr = agent_wren[win];
    assign win_rd = !win_wr && agent_rden[win];
    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
    assign full = tag_cnt == (TW+1)'(MAX_RD_OUTSTANDING);
    assign issue = !rst && en && |req && cntrlr_rdy && !(win_rd && full);
    assign grant = issue ? NUM_AGENTS'(1) << win : '0;

    assign cntrlr_wren = issue && win_wr;
    assign cntrlr_rden = issue && win_rd;
    assign cntrlr_addr = issue ? agent_addr[int'(win)*MEM_ADDR_W +: MEM_ADDR_W] : '0;
    assign cntrlr_wdata = issue ? agent_wdata[int'(win)*MEM_DATA_W +: MEM_DATA_W] : '0;
    assign agent_wait = req & ~grant;

    // A grant to the same agent past BURST_LEN starts a fresh burst rather than overflowing.
    assign burst_nxt = (burst_cnt != '0 && win == last && burst_cnt < BL) ? burst_cnt + 1'b1 : BW'(1);

    assign push = issue && win_rd;
    assign pop = cntrlr_rd_valid && tag_cnt != '0;
    assign underflow = cntrlr_rd_valid && tag_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
            last <= '0;
            rr_ptr <= '0;
            wp <= '0;
            rp <= '0;
            tag_cnt <= '0;
            agent_rd_valid <= '0;
            agent_rdata <= '0;
        end else begin
            burst_cnt <= issue ? burst_nxt : '0;
            last <= issue ? win : last;
            rr_ptr <= (issue && burst_nxt == BL) ? inc(win) : drop ? inc(last) : rr_ptr;
            wp <= wp + TW'(push);
            rp <= rp + TW'(pop);
            tag_cnt <= tag_cnt + (TW+1)'(push) - (TW+1)'(pop);
            agent_rd_valid <= pop ? NUM_AGENTS'(1) << tag_mem[rp] : '0;
            agent_rdata <= pop ? cntrlr_rdata : agent_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wp] <= win;
    end

    assign ctl_wr = lb_wr_en && lb_addr == LB_ADDR_W'(0);
    assign st_wr = lb_wr_en && lb_addr == LB_ADDR_W'(1);

`ifdef SYS_MEM_ARB_STATS_EN
    logic [31:0]          grant_cnt [NUM_AGENTS];
    logic [LB_ADDR_W-1:0] stat_off;

    assign stat_off = lb_addr - LB_ADDR_W'(16);
    assign stat_hit = lb_addr >= LB_ADDR_W'(16) && lb_addr < LB_ADDR_W'(16 + NUM_AGENTS);
    assign stat_rd = LB_DATA_W'(grant_cnt[stat_off[AW-1:0]]);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_AGENTS; i++) begin
            if (rst || (lb_wr_en && stat_hit && stat_off == LB_ADDR_W'(i)))
                grant_cnt[i] <= '0;
            else if (grant[i] && grant_cnt[i] != '1)
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
    end
`else
    assign stat_hit = 1'b0;
    assign stat_rd = '0;
`endif

    assign rd_mux = (lb_addr == LB_ADDR_W'(0)) ? LB_DATA_W'({mode, en}) :
                    (lb_addr == LB_ADDR_W'(1)) ? LB_DATA_W'({8'(tag_cnt), 7'b0, rd_underflow}) :
                    stat_hit ? stat_rd : DEFAULT_DATA_VAL;

    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b1;
            mode <= 1'b1;
            rd_underflow <= 1'b0;
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data <= '0;
        end else begin
            en <= ctl_wr ? lb_wr_data[0] : en;
            mode <= ctl_wr ? lb_wr_data[1] : mode;
            // A new underflow in the clearing cycle keeps the flag set.
            rd_underflow <= underflow || (rd_underflow && !(st_wr && lb_wr_data[0]));
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            lb_rd_data <= lb_rd_en ? rd_mux : lb_rd_data;
        end
    end
endmodule

// File: tb/tb_sys_mem_arb_nx.sv
// tb_sys_mem_arb_nx: self-checking bench for sys_mem_arb_nx (default build, 4 agents)
module tb_sys_mem_arb_nx;
    logic         clk, rst, lb_wr_en, lb_rd_en, lb_wr_valid, lb_rd_valid;
    logic [11:0]  lb_addr;
    logic [31:0]  lb_wr_data, lb_rd_data;
    logic [3:0]   agent_wren, agent_rden, agent_wait, agent_rd_valid;
    logic [107:0] agent_addr;
    logic [127:0] agent_wdata;
    logic [31:0]  agent_rdata, cntrlr_wdata, cntrlr_rdata;
    logic         cntrlr_rdy, cntrlr_wren, cntrlr_rden, cntrlr_rd_valid;
    logic [26:0]  cntrlr_addr;

    typedef struct {
        logic [3:0] wr;
        logic [3:0] rd;
        logic       rdy;
        int         win;
        logic       iss;
        logic [3:0] wt;
    } vec_t;

    typedef struct {
        int          agent;
        logic [31:0] data;
    } exp_t;

    vec_t vt [64];
    int   nv, na;
    exp_t sb [$];
    int   errors, checks;

    sys_mem_arb_nx dut (
        .clk(clk), .rst(rst),
        .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
        .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
        .agent_wren(agent_wren), .agent_rden(agent_rden), .agent_addr(agent_addr),
        .agent_wdata(agent_wdata), .agent_wait(agent_wait), .agent_rd_valid(agent_rd_valid),
        .agent_rdata(agent_rdata), .cntrlr_rdy(cntrlr_rdy), .cntrlr_wren(cntrlr_wren),
        .cntrlr_rden(cntrlr_rden), .cntrlr_addr(cntrlr_addr), .cntrlr_wdata(cntrlr_wdata),
        .cntrlr_rd_valid(cntrlr_rd_valid), .cntrlr_rdata(cntrlr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, required end of test");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [3:0] wr, logic [3:0] rd, logic rdy, int win, logic iss, logic [3:0] wt);
        vec_t v;
        v.wr = wr;
        v.rd = rd;
        v.rdy = rdy;
        v.win = win;
        v.iss = iss;
        v.wt = wt;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vt[nv] = v;
        nv++;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (|agent_rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_return: got agent_rd_valid %b expected none", agent_rd_valid);
            end else begin
                e = sb.pop_front();
                chk("rd_valid", 32'(agent_rd_valid), 32'(1) << e.agent);
                chk("rd_data", agent_rdata, e.data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic apply(input vec_t v, input string n);
        agent_wren = v.wr;
        agent_rden = v.rd;
        cntrlr_rdy = v.rdy;
        #1;
        chk({n, "_wren"}, 32'(cntrlr_wren), 32'(v.iss & v.wr[v.win]));
        chk({n, "_rden"}, 32'(cntrlr_rden), 32'(v.iss & ~v.wr[v.win] & v.rd[v.win]));
        chk({n, "_addr"}, 32'(cntrlr_addr), v.iss ? 32'h100 + 32'(v.win) : 32'h0);
        chk({n, "_wdata"}, cntrlr_wdata, v.iss ? 32'hA000_0000 + 32'(v.win) : 32'h0);
        chk({n, "_wait"}, 32'(agent_wait), 32'(v.wt));
        tick();
    endtask

    task automatic idle();
        apply(mk(4'b0, 4'b0, 1'b1, 0, 1'b0, 4'b0), "idle");
    endtask

    task automatic lb_wr(input logic [11:0] a, input logic [31:0] d);
        lb_wr_en = 1'b1;
        lb_addr = a;
        lb_wr_data = d;
        tick();
        lb_wr_en = 1'b0;
        chk($sformatf("lb_wr_valid@%0h", a), 32'(lb_wr_valid), 32'h1);
    endtask

    task automatic lb_rd(input logic [11:0] a, input logic [31:0] e);
        lb_rd_en = 1'b1;
        lb_addr = a;
        tick();
        lb_rd_en = 1'b0;
        chk($sformatf("lb_rd_valid@%0h", a), 32'(lb_rd_valid), 32'h1);
        chk($sformatf("lb_rd_data@%0h", a), lb_rd_data, e);
    endtask

    task automatic ret(input int agent, input logic [31:0] d);
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata = d;
        sb.push_back('{agent, d});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nv = 0;
        for (int c = 0; c < 20; c++) add(mk(4'hF, 4'h0, 1'b1, (c / 4) % 4, 1'b1, 4'hF ^ (4'b1 << ((c / 4) % 4))));
        add(mk(4'hF, 4'h0, 1'b0, 0, 1'b0, 4'hF));
        add(mk(4'hF, 4'h0, 1'b1, 1, 1'b1, 4'b1101));
        add(mk(4'b1101, 4'h0, 1'b1, 2, 1'b1, 4'b1001));
        add(mk(4'b1101, 4'h0, 1'b1, 2, 1'b1, 4'b1001));
        add(mk(4'b0001, 4'h0, 1'b1, 0, 1'b1, 4'b0000));
        add(mk(4'b0000, 4'h0, 1'b1, 0, 1'b0, 4'b0000));
        na = nv;
        for (int c = 0; c < 6; c++) add(mk(4'b1010, 4'h0, 1'b1, 1, 1'b1, 4'b1000));
        add(mk(4'b1000, 4'h0, 1'b1, 3, 1'b1, 4'b0000));
        add(mk(4'b1000, 4'h0, 1'b1, 3, 1'b1, 4'b0000));
        add(mk(4'b1001, 4'h0, 1'b1, 3, 1'b1, 4'b0001));
        add(mk(4'b1001, 4'h0, 1'b1, 3, 1'b1, 4'b0001));
        add(mk(4'b1001, 4'h0, 1'b1, 0, 1'b1, 4'b1000));
        add(mk(4'b0001, 4'b0001, 1'b1, 0, 1'b1, 4'b0000));
        add(mk(4'b0000, 4'h0, 1'b1, 0, 1'b0, 4'b0000));

        for (int i = 0; i < 4; i++) begin
            agent_addr[i*27 +: 27] = 27'h100 + 27'(i);
            agent_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end
        rst = 1'b1;
        lb_wr_en = 1'b0;
        lb_rd_en = 1'b0;
        lb_addr = '0;
        lb_wr_data = '0;
        agent_wren = 4'hF;
        agent_rden = 4'h0;
        cntrlr_rdy = 1'b1;
        cntrlr_rd_valid = 1'b0;
        cntrlr_rdata = '0;
        tick();
        chk("rst_wait", 32'(agent_wait), 32'hF);
        chk("rst_cwren", 32'(cntrlr_wren), 32'h0);
        chk("rst_caddr", 32'(cntrlr_addr), 32'h0);
        rst = 1'b0;
        agent_wren = 4'h0;
        tick();
        chk("rst_rd_valid", 32'(agent_rd_valid), 32'h0);
        chk("rst_rdata", agent_rdata, 32'h0);
        chk("rst_lb_valid", {30'h0, lb_wr_valid, lb_rd_valid}, 32'h0);
        chk("rst_lb_data", lb_rd_data, 32'h0);
        lb_rd(12'h0, 32'h3);
        lb_rd(12'h1, 32'h0);
        tick();
        chk("lb_rd_valid_pulse", 32'(lb_rd_valid), 32'h0);

        for (int i = 0; i < na; i++) apply(vt[i], $sformatf("rr%0d", i));
        lb_wr(12'h0, 32'h1);
        for (int i = na; i < nv; i++) apply(vt[i], $sformatf("fp%0d", i));

        for (int i = 0; i < 8; i++) apply(mk(4'h0, 4'b0100, 1'b1, 2, 1'b1, 4'h0), "fill");
        apply(mk(4'h0, 4'b0100, 1'b1, 2, 1'b0, 4'b0100), "full_rd");
        apply(mk(4'b0001, 4'b0100, 1'b1, 0, 1'b1, 4'b0100), "full_wr");
        idle();
        lb_rd(12'h1, 32'h0000_0800);
        ret(2, 32'h1234_5678);
        apply(mk(4'h0, 4'b0100, 1'b1, 2, 1'b0, 4'b0100), "pop_push");
        cntrlr_rd_valid = 1'b0;
        apply(mk(4'h0, 4'b0100, 1'b1, 2, 1'b1, 4'h0), "refill");
        idle();
        for (int k = 0; k < 8; k++) begin
            ret(2, 32'h100 + 32'(k));
            tick();
        end
        cntrlr_rd_valid = 1'b0;
        tick();
        lb_rd(12'h1, 32'h0);

        apply(mk(4'h0, 4'b0001, 1'b1, 0, 1'b1, 4'h0), "il0");
        apply(mk(4'h0, 4'b1000, 1'b1, 3, 1'b1, 4'h0), "il3");
        apply(mk(4'h0, 4'b0010, 1'b1, 1, 1'b1, 4'h0), "il1");
        idle();
        ret(0, 32'hA);
        tick();
        ret(3, 32'hB);
        tick();
        ret(1, 32'hC);
        tick();
        cntrlr_rd_valid = 1'b0;
        tick();

        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata = 32'h77;
        tick();
        cntrlr_rd_valid = 1'b0;
        tick();
        chk("underflow_no_valid", 32'(agent_rd_valid), 32'h0);
        lb_rd(12'h1, 32'h1);
        lb_wr(12'h1, 32'h1);
        lb_rd(12'h1, 32'h0);
        cntrlr_rd_valid = 1'b1;
        lb_wr(12'h1, 32'h1);
        cntrlr_rd_valid = 1'b0;
        lb_rd(12'h1, 32'h1);
        lb_wr(12'h1, 32'h1);
        lb_rd(12'h1, 32'h0);

        apply(mk(4'h0, 4'b0010, 1'b1, 1, 1'b1, 4'h0), "dis_rd");
        idle();
        lb_wr(12'h0, 32'h0);
        apply(mk(4'b0011, 4'h0, 1'b1, 0, 1'b0, 4'b0011), "dis0");
        ret(1, 32'h55);
        apply(mk(4'b0011, 4'h0, 1'b1, 0, 1'b0, 4'b0011), "dis1");
        cntrlr_rd_valid = 1'b0;
        idle();
        lb_rd(12'h5, 32'hdeadbabe);
        lb_rd(12'h10, 32'hdeadbabe);
        lb_rd(12'h0, 32'h0);
        lb_wr(12'h0, 32'h1);
        apply(mk(4'b0011, 4'h0, 1'b1, 0, 1'b1, 4'b0010), "reen");
        idle();

        apply(mk(4'h0, 4'b1000, 1'b1, 3, 1'b1, 4'h0), "pre_rst");
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata = 32'h99;
        tick();
        cntrlr_rd_valid = 1'b0;
        tick();
        chk("rst_drop_no_valid", 32'(agent_rd_valid), 32'h0);
        lb_rd(12'h1, 32'h1);
        lb_rd(12'h0, 32'h3);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
